// File: rtl/lstm_x_fetch.sv
`timescale 1ns/1ps
// lstm_x_fetch
// Streams NUM-element x vectors out of the x memory into the LSTM core,
// one vector per timestep, NUM_ITERATIONS timesteps per run.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous, active-high reset
//   start    in   begin a run (only honoured in IDLE)
//   rd_en    out  x memory read strobe
//   addr     out  x memory read address (persists across runs, wraps at X_DEPTH)
//   rd_data  in   x memory data, valid one cycle after rd_en
//   x_vec    out  packed vector, element k at [k*WIDTH +: WIDTH]
//   x_valid  out  x_vec valid (PRESENT only)
//   x_ready  in   core accepts x_vec
//   busy     out  high whenever not IDLE
//   done     out  one-cycle pulse when the run ends
module lstm_x_fetch #(
    parameter int WIDTH          = 16,
    parameter int NUM            = 3,
    parameter int NUM_ITERATIONS = 5,
    parameter int X_DEPTH        = 360,
    parameter int ADDR_WIDTH     = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      rd_data,
    output logic [NUM*WIDTH-1:0]  x_vec,
    output logic                  x_valid,
    input  logic                  x_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int K_W  = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int IT_W = (NUM_ITERATIONS > 1) ? $clog2(NUM_ITERATIONS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t                     r_state;
    logic [K_W-1:0]             r_k;        // read index within current timestep
    logic [K_W-1:0]             r_cap_idx;  // element slot for data arriving this cycle
    logic                       r_cap_en;   // a read was issued last cycle
    logic [IT_W-1:0]            r_iter;
    logic [NUM-1:0][WIDTH-1:0]  r_x;
    logic                       r_rd_en;
    logic [ADDR_WIDTH-1:0]      r_addr;
    logic                       r_x_valid;
    logic                       r_busy;
    logic                       r_done;

    logic                       w_last_rd;
    logic                       w_last_iter;
    logic [ADDR_WIDTH-1:0]      w_addr_nxt;

    assign w_last_rd   = (r_k == K_W'(NUM - 1));
    assign w_last_iter = (r_iter == IT_W'(NUM_ITERATIONS - 1));
    assign w_addr_nxt  = (r_addr == ADDR_WIDTH'(X_DEPTH - 1)) ? '0 : r_addr + ADDR_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_cap_idx <= '0;
            r_cap_en  <= 1'b0;  // drops any read still in flight
            r_iter    <= '0;
            r_x       <= '0;
            r_rd_en   <= 1'b0;
            r_addr    <= '0;
            r_x_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            // Memory answers one cycle after the strobe: remember which slot
            // the returning word belongs to and write it when it lands.
            r_cap_en  <= r_rd_en;
            r_cap_idx <= r_k;
            if (r_cap_en)
                r_x[r_cap_idx] <= rd_data;

            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_FETCH;
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                        r_k     <= '0;
                    end
                end
                S_FETCH: begin
                    r_addr <= w_addr_nxt;
                    if (w_last_rd) begin
                        r_rd_en <= 1'b0;
                        r_state <= S_WAIT;
                    end else begin
                        r_k <= r_k + K_W'(1);
                    end
                end
                S_WAIT: begin
                    // last element is captured on this edge by the path above
                    r_state   <= S_PRESENT;
                    r_x_valid <= 1'b1;
                end
                S_PRESENT: begin
                    if (x_ready) begin
                        r_x_valid <= 1'b0;
                        if (w_last_iter) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_iter  <= r_iter + IT_W'(1);
                            r_state <= S_FETCH;
                            r_rd_en <= 1'b1;
                            r_k     <= '0;
                        end
                    end
                end
                S_DONE: begin
                    r_iter  <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_en   = r_rd_en;
    assign addr    = r_addr;
    assign x_vec   = r_x;
    assign x_valid = r_x_valid;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: doc/lstm_x_fetch.md
LSTM_X_FETCH -- requirements
Module: lstm_x_fetch

Interface
REQ-001 SHALL have parameter WIDTH, default 16: bit width of one x element.
REQ-002 SHALL have parameter NUM, default 3: x elements per timestep vector.
REQ-003 SHALL have parameter NUM_ITERATIONS, default 5: timesteps per run.
REQ-004 SHALL have parameter X_DEPTH, default 360: x memory depth in words.
REQ-005 SHALL have parameter ADDR_WIDTH, default 9: address width; X_DEPTH <= 2^ADDR_WIDTH.
REQ-006 SHALL have port clk  input  1  clock, rising-edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port start  input  1  begin one run of NUM_ITERATIONS vectors.
REQ-009 SHALL have port rd_en  output  1  x memory read strobe.
REQ-010 SHALL have port addr  output  ADDR_WIDTH  x memory read address.
REQ-011 SHALL have port rd_data  input  WIDTH  x memory data, valid exactly 1 cycle after rd_en.
REQ-012 SHALL have port x_vec  output  NUM*WIDTH  packed vector to LSTM core.
REQ-013 SHALL have port x_valid  output  1  x_vec valid.
REQ-014 SHALL have port x_ready  input  1  LSTM core accepts x_vec.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse at run end.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, WAIT, PRESENT, DONE.
REQ-018 IDLE: start=1 -> FETCH; start ignored in all other states.
REQ-019 FETCH: rd_en=1 for exactly NUM consecutive cycles, addr advancing by 1 each read; after NUM-th read -> WAIT.
REQ-020 addr SHALL wrap X_DEPTH-1 -> 0; addr holds its value between runs (next run continues from it).
REQ-021 rd_data returned for the k-th read of a timestep (k=0..NUM-1) SHALL be registered into x_vec[k*WIDTH +: WIDTH].
REQ-022 WAIT: captures last element, lasts one cycle -> PRESENT.
REQ-023 PRESENT: x_valid=1; x_vec and addr stable; rd_en=0 until x_valid&&x_ready.
REQ-024 Handshake in PRESENT: if timestep counter == NUM_ITERATIONS-1 -> DONE, else increment counter -> FETCH.
REQ-025 DONE: done=1 for one cycle, timestep counter cleared -> IDLE.
REQ-026 Latency: start sampled at cycle t -> rd_en cycles t+1..t+NUM -> x_valid first high at t+NUM+2.
REQ-027 x_valid SHALL never be high outside PRESENT; x_ready outside PRESENT SHALL be ignored.
REQ-028 Throughput with x_ready=1: one vector per NUM+2 cycles.

Reset
REQ-029 rst=1 SHALL, at next clock edge, force IDLE, addr=0, timestep counter=0, x_vec=0, rd_en=0, x_valid=0, busy=0, done=0.
REQ-030 rst SHALL take priority over start and x_ready in any state, including mid-FETCH and PRESENT; outstanding read data SHALL be discarded.

Verification
REQ-031 Reset: rst high 2 cycles -> all outputs 0, addr=0.
REQ-032 Nominal (NUM=3, NUM_ITERATIONS=5, memory word=addr+100, x_ready=1): start at cycle 0 -> x_valid at cycle 5 with x_vec={102,101,100}; 5 vectors total, every 5 cycles; done pulse once; addr=15 afterwards.
REQ-033 Backpressure: x_ready low 4 cycles during PRESENT -> x_valid held high, x_vec unchanged, rd_en=0, vector accepted once x_ready=1.
REQ-034 Wrap (X_DEPTH=16): second run reads addresses 15,0,1 for first vector -> x_vec={101,100,115}.
REQ-035 Start while busy pulsed mid-run -> no effect on sequence; rst during FETCH -> IDLE, addr=0, no x_valid, no done.
